reg_in: RTL and testbench

- SAP-1 input port: the counterpart of the output register.
- An external device (switch bank, keypad, test host) pushes bytes through a valid/ready handshake into a small show-ahead FIFO.
- During an IN-type control step the controller asserts rd. The port drives the head byte onto the W bus combinationally, and the accumulator loads it at the clock edge that pops the entry.
- Sits beside reg_out on the bus. It is the only bus driver while rd is high.

---
 rtl/sap1_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/reg_in.sv | 63 ++++++
 tb/tb_reg_in.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: datapath word width and the W-bus source encoding
// used by the controller's bus multiplexer.
package sap1_pkg;

   localparam int WORD_W = 8;

   typedef enum logic [2:0] {
      BUS_SRC_NONE = 3'd0,
      BUS_SRC_PC   = 3'd1,
      BUS_SRC_RAM  = 3'd2,
      BUS_SRC_IR   = 3'd3,
      BUS_SRC_ACC  = 3'd4,
      BUS_SRC_ALU  = 3'd5,
      BUS_SRC_IN   = 3'd6
   } bus_src_e;

   // Select code the controller uses when reg_in owns the W bus.
   localparam bus_src_e BUS_SRC_REG_IN = BUS_SRC_IN;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: head entry is visible on rd_data without a read
// strobe; push/pop are qualified here so callers may drive them loosely.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             do_push;
   logic             do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == FULL_CNT);
   assign count   = cnt;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // Storage carries no reset; stale contents are masked by empty.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/reg_in.sv
// SAP-1 input port: external bytes enter a small FIFO through valid/ready and
// are driven onto the W bus combinationally while the controller holds rd.
module reg_in
   import sap1_pkg::*;
#(
   parameter int WIDTH = WORD_W,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       rd,
   output logic [WIDTH-1:0]           bus_out,
   output logic                       bus_en,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       underflow,
   input  logic                       clr_err
);

   logic [WIDTH-1:0] head;
   logic             push;
   logic             pop;

   // Ready comes from registered state only, so rd never reaches in_ready;
   // a pop from full frees the slot for the following cycle.
   assign in_ready = rst && !full;
   assign push     = in_valid && in_ready;
   assign pop      = rd && !empty;

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .wr_data (in_data),
      .pop     (pop),
      .rd_data (head),
      .empty   (empty),
      .full    (full),
      .count   (count)
   );

   assign bus_en  = rd;
   assign bus_out = pop ? head : '0;

   // Set outranks clear when both happen on the same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         underflow <= 1'b0;
      end else if (rd && empty) begin
         underflow <= 1'b1;
      end else if (clr_err) begin
         underflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_reg_in.sv
// Bench for reg_in: directed steps followed by a randomized run, all compared
// against a queue-based model of the port.
module tb_reg_in;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             rd = 1'b0;
   logic [WIDTH-1:0] bus_out;
   logic             bus_en;
   logic             empty;
   logic             full;
   logic [CW-1:0]    count;
   logic             underflow;
   logic             clr_err = 1'b0;

   int errors = 0;
   int checks = 0;

   byte unsigned q[$];
   bit           uf_m = 1'b0;

   reg_in #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rd        (rd),
      .bus_out   (bus_out),
      .bus_en    (bus_en),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .underflow (underflow),
      .clr_err   (clr_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_regs(input string tag);
      chk({tag, ".count"}, 32'(count), 32'(q.size()));
      chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
      chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
      chk({tag, ".underflow"}, 32'(underflow), 32'(uf_m));
   endtask

   // One clock cycle: drive inputs, check combinational outputs before the
   // edge, advance the model, check registered state after the edge.
   task automatic cycle(input logic v, input logic [7:0] d, input logic r,
                        input logic c, input string tag);
      logic [7:0] exp_bus;
      bit         do_push;
      bit         do_pop;
      in_valid = v;
      in_data  = d;
      rd       = r;
      clr_err  = c;
      #3;
      exp_bus = (r && q.size() != 0) ? q[0] : 8'h00;
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < DEPTH));
      chk({tag, ".bus_en"}, 32'(bus_en), 32'(r));
      chk({tag, ".bus_out"}, 32'(bus_out), 32'(exp_bus));
      do_push = v && (q.size() < DEPTH);
      do_pop  = r && (q.size() != 0);
      if (r && q.size() == 0) uf_m = 1'b1;
      else if (c) uf_m = 1'b0;
      @(posedge clk);
      #1;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d);
      chk_regs(tag);
   endtask

   initial begin
      // Reset held with a byte on offer.
      rst = 1'b0; in_valid = 1'b1; in_data = 8'hAA; rd = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.in_ready", 32'(in_ready), 32'd0);
      chk("rst.empty", 32'(empty), 32'd1);
      chk("rst.full", 32'(full), 32'd0);
      chk("rst.count", 32'(count), 32'd0);
      chk("rst.bus_out", 32'(bus_out), 32'h00);
      chk("rst.underflow", 32'(underflow), 32'd0);
      rst = 1'b1;
      #1;
      chk("rel.in_ready", 32'(in_ready), 32'd1);
      chk("rel.count", 32'(count), 32'd0);
      cycle(1'b1, 8'hAA, 1'b0, 1'b0, "rel.push");
      cycle(1'b0, 8'h00, 1'b1, 1'b0, "rel.pop");

      // Ordering.
      cycle(1'b1, 8'h2A, 1'b0, 1'b0, "ord.p0");
      cycle(1'b1, 8'hFF, 1'b0, 1'b0, "ord.p1");
      cycle(1'b1, 8'h3C, 1'b0, 1'b0, "ord.p2");
      for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "ord.rd");
      chk("ord.final_empty", 32'(empty), 32'd1);

      // Full backpressure.
      for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, "bp.fill");
      cycle(1'b1, 8'h05, 1'b0, 1'b0, "bp.offer");
      chk("bp.full", 32'(full), 32'd1);
      cycle(1'b1, 8'h05, 1'b1, 1'b0, "bp.pop_full");
      cycle(1'b1, 8'h05, 1'b0, 1'b0, "bp.accept");
      chk("bp.count_after", 32'(count), 32'd4);
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "bp.drain");

      // Underflow set / clear / set-wins.
      cycle(1'b0, 8'h00, 1'b1, 1'b0, "uf.set");
      cycle(1'b0, 8'h00, 1'b0, 1'b1, "uf.clr");
      cycle(1'b0, 8'h00, 1'b1, 1'b1, "uf.setwins");
      cycle(1'b0, 8'h00, 1'b0, 1'b1, "uf.clr2");
      cycle(1'b1, 8'h5A, 1'b1, 1'b0, "uf.push_rd_empty");
      cycle(1'b0, 8'h00, 1'b1, 1'b1, "uf.drain");

      // Simultaneous push/pop and pointer wrap.
      cycle(1'b1, 8'h0F, 1'b0, 1'b0, "pp.p0");
      cycle(1'b1, 8'h2A, 1'b0, 1'b0, "pp.p1");
      cycle(1'b1, 8'h77, 1'b1, 1'b0, "pp.both");
      for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h78 + i), 1'b1, 1'b0, "pp.wrap");
      for (int i = 0; i < 2; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "pp.drain");

      // Asynchronous reset mid-operation.
      cycle(1'b1, 8'hC1, 1'b0, 1'b0, "mr.p0");
      cycle(1'b1, 8'hC2, 1'b0, 1'b0, "mr.p1");
      cycle(1'b1, 8'hC3, 1'b0, 1'b0, "mr.p2");
      in_valid = 1'b1; in_data = 8'hC4; rd = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      q.delete();
      uf_m = 1'b0;
      chk("mr.in_ready", 32'(in_ready), 32'd0);
      chk_regs("mr.async");
      @(posedge clk);
      #1;
      chk_regs("mr.held");
      rst = 1'b1;
      in_valid = 1'b0;
      cycle(1'b0, 8'h00, 1'b1, 1'b0, "mr.rd_after");
      cycle(1'b0, 8'h00, 1'b0, 1'b1, "mr.clr");

      // Randomized traffic: fill-biased, then drain-biased, then balanced.
      for (int i = 0; i < 600; i++) begin
         int pv;
         int pr;
         pv = (i < 200) ? 80 : (i < 400) ? 25 : 50;
         pr = (i < 200) ? 25 : (i < 400) ? 80 : 50;
         cycle(1'($urandom_range(0, 99) < pv), 8'($urandom),
               1'($urandom_range(0, 99) < pr), 1'($urandom_range(0, 9) == 0),
               "rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
